// File: rtl/seq_divider_pkg.sv
// Shared ALU definitions for the sequential divider: state encoding, default
// widths and the divide-by-zero quotient pattern.
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_CW    = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Every quotient bit is set on divide-by-zero.
  localparam logic DZ_QUOTIENT_BIT = 1'b1;

endpackage

// File: rtl/fulladder.sv
// One-bit full adder cell shared by the ALU adder and subtractor paths.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/sub16.sv
// Combinational N-bit ripple subtractor (a - b) built from full adders using
// two's complement: inverted b and a carry-in of 1.
module sub16
  import seq_divider_pkg::*;
#(
  parameter int N = DEFAULT_WIDTH + 1
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  logic [N:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_bit
    fulladder u_fa (
      .a    (a[i]),
      .b    (~b[i]),
      .cin  (carry[i]),
      .s    (diff[i]),
      .cout (carry[i+1])
    );
  end

  // A missing carry out of the top bit means a < b.
  assign borrow = ~carry[N];

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one trial subtraction per clock, with
// a start/busy/done handshake and registered quotient/remainder/dz results.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = DEFAULT_CW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             dz
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_acc_q, rem_acc_d;
  logic [WIDTH-1:0] quo_sh_q, quo_sh_d;
  logic [WIDTH-1:0] div_reg_q, div_reg_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [1:0]       unused_msbs;

  // The partial remainder stays below 2^k after k steps, so its MSB is
  // always zero when shifted and the zero-extended subtract is exact.
  assign shifted     = {rem_acc_q[WIDTH-2:0], quo_sh_q[WIDTH-1]};
  assign unused_msbs = {rem_acc_q[WIDTH-1], trial[WIDTH]};

  sub16 #(.N(WIDTH + 1)) u_sub (
    .a      ({1'b0, shifted}),
    .b      ({1'b0, div_reg_q}),
    .diff   (trial),
    .borrow (borrow)
  );

  always_comb begin
    state_d   = state_q;
    rem_acc_d = rem_acc_q;
    quo_sh_d  = quo_sh_q;
    div_reg_d = div_reg_q;
    cnt_d     = cnt_q;
    q_d       = q_q;
    r_d       = r_q;
    dz_d      = dz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (y == '0) begin
            q_d     = {WIDTH{DZ_QUOTIENT_BIT}};
            r_d     = x;
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            rem_acc_d = '0;
            quo_sh_d  = x;
            div_reg_d = y;
            cnt_d     = '0;
            dz_d      = 1'b0;
            state_d   = DIV;
          end
        end
      end
      DIV: begin
        rem_acc_d = borrow ? shifted : trial[WIDTH-1:0];
        quo_sh_d  = {quo_sh_q[WIDTH-2:0], ~borrow};
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          q_d     = quo_sh_d;
          r_d     = rem_acc_d;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rem_acc_q <= '0;
      quo_sh_q  <= '0;
      div_reg_q <= '0;
      cnt_q     <= '0;
      q_q       <= '0;
      r_q       <= '0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_acc_q <= rem_acc_d;
      quo_sh_q  <= quo_sh_d;
      div_reg_q <= div_reg_d;
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      r_q       <= r_d;
      dz_q      <= dz_d;
    end
  end

  assign q    = q_q;
  assign r    = r_q;
  assign dz   = dz_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative unsigned restoring divider for the ALU. It is the inverse of the adder/multiplier path: one trial subtraction per clock.
- Computes quotient and remainder of x / y for WIDTH-bit operands using a start/busy/done handshake.
- Sits beside the ripple adder in the ALU. The ALU sequencer issues a start and waits for done.

Parameters:
- WIDTH, 16, operand/quotient/remainder width in bits.
- CW, 5, iteration counter width; must satisfy 2^CW > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- x  input  WIDTH  dividend; captured on accepted start
- y  input  WIDTH  divisor; captured on accepted start
- q  output  WIDTH  quotient; registered, held until next accepted start
- r  output  WIDTH  remainder; registered, held until next accepted start
- busy  output  1  high while a division is in progress (states DIV and DONE)
- done  output  1  one-cycle pulse; q/r/dz valid from this cycle onward
- dz  output  1  divide-by-zero flag for the last result; registered

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - q, r, busy, done, dz are all 0.
  - Internal accumulator, shift register and counter are cleared.
- States: IDLE, DIV, DONE.
- IDLE:
  - If start=1 at edge N with y!=0:
    - Load rem_acc=0, quo_sh=x, div_reg=y, cnt=0.
    - Clear dz; go to DIV; busy=1 from N.
  - If start=1 with y==0:
    - Go directly to DONE with q=all-ones, r=x, dz=1.
    - done is high in the cycle after edge N (latency 1).
- DIV, one step per edge:
  - Form trial = {rem_acc[WIDTH-2:0], quo_sh[WIDTH-1]} minus div_reg. Use a WIDTH+1-bit subtract; the borrow is the MSB.
  - No borrow: rem_acc=trial[WIDTH-1:0] and shift a 1 into quo_sh LSB.
  - Borrow: rem_acc = shifted value (restore) and shift a 0 into quo_sh LSB.
  - quo_sh shifts left each step; cnt increments.
  - Shifted-out remainder bit: the partial remainder is always < div_reg, so the WIDTH+1-bit compare is exact. No overflow is possible.
  - After the WIDTH-th step (edge N+WIDTH): q=quo_sh final, r=rem_acc final, state goes to DONE.
- DONE:
  - done=1 and busy=1 for exactly one cycle (the cycle after edge N+WIDTH, i.e. latency WIDTH+1 from start).
  - Next edge goes to IDLE; done and busy drop to 0.
- start is ignored in DIV and DONE. No queuing: a start during busy is lost.
  - start in the same cycle busy falls (IDLE) is accepted.
- Operand registers are captured at start, so x/y may change freely during DIV.
- q/r/dz stay stable from done until the next accepted start.
  - On the next accepted start they keep their old values until that division's DONE.
  - Exception: dz clears at the accepted start.
- Reset asserted mid-operation aborts immediately.
  - No done pulse; all outputs are 0 on release.
  - First start after release behaves normally.
- x=0: q=0, r=0, done at latency WIDTH+1.
- x<y: q=0, r=x.

Decomposition:
- Shared ALU package:
  - State encoding constants IDLE=2'd0, DIV=2'd1, DONE=2'd2.
  - Default WIDTH=16.
  - Divide-by-zero quotient constant (all-ones).
- One sub-module: sub16, a combinational WIDTH+1-bit subtractor (a - b, borrow out).
  - Built from the existing fulladder cells with inverted b and carry-in 1.
  - Instantiated once for the trial subtraction.
- The FSM, counter and shift registers stay in seq_divider.

Test Plan:
- x=100, y=7, start at edge N -> busy=1 from N, done pulse in cycle N+17, q=14, r=2, dz=0; q/r held afterward.
- x=16'hFFFF, y=1 -> q=16'hFFFF, r=0; x=16'hFFFF, y=16'hFFFF -> q=1, r=0; x=3, y=10 -> q=0, r=3.
- x=5, y=0 -> done in cycle N+1, q=16'hFFFF, r=5, dz=1; next division 9/3 -> dz=0 at its start, q=3, r=0.
- start re-pulsed with x=50, y=5 during DIV of 100/7 -> ignored; result stays 14/2 and exactly one done pulse occurs. Then start in the cycle after done -> 50/5 gives q=10, r=0.
- rst_n low at step 8 of 1000/3 -> q=r=busy=done=dz=0 immediately (asynchronous), no done pulse. After release, 1000/3 -> q=333, r=1.
- Random sweep of 10k (x, y) pairs, y!=0, checked against a reference model: q*y+r==x, r<y, latency exactly 17 every time.
